// File: rtl/rx_core.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rx_core
// Purpose  : UART receiver, 8 data bits LSB first, 1 stop bit, with a
//            one-byte valid/ready holding register plus frame-error and
//            overrun pulses. Optional even-parity bit when the macro
//            UART_RX_PARITY_EN is defined (adds PARITY state and the
//            rx_parity_err output).
// Ports    : rx_clk        in   clock, rising edge
//            reset         in   synchronous, active-high
//            rx            in   asynchronous serial line, idle high
//            rx_valid      out  rx_data holds an unconsumed byte
//            rx_data[7:0]  out  received byte
//            rx_ready      in   sink accepts when rx_valid && rx_ready
//            rx_frame_err  out  1-cycle pulse, stop bit sampled low
//            rx_overrun    out  1-cycle pulse, completed byte dropped
//            rx_parity_err out  1-cycle pulse, parity mismatch
//                               (UART_RX_PARITY_EN builds only)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module rx_core #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       rx_clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       rx_parity_err
`endif
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] c_half_m1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] c_full_m1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd3
  } state_t;

  // Synchronizer and edge-detect history; all reset high so a line that is
  // already low after reset is not mistaken for a start edge.
  logic             sync1_q;
  logic             rx_s_q;
  logic             rx_prev_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             byte_done;
`ifdef UART_RX_PARITY_EN
  logic             perr_q, perr_d;
  logic             pbad_q, pbad_d;
`endif

  always_ff @(posedge rx_clk) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      pbad_q    <= 1'b0;
`endif
    end else begin
      sync1_q   <= rx;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      pbad_q    <= pbad_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    byte_done = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    pbad_d    = pbad_q;
`endif

    // Sink handshake; a byte completing in the same cycle re-raises valid below.
    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
`ifdef UART_RX_PARITY_EN
        pbad_d = 1'b0;
`endif
        // Needs a genuine high-to-low transition, so a line stuck low after
        // a frame error or reset cannot start a frame.
        if (!rx_s_q && rx_prev_q) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == c_half_m1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        // Counting restarts at the start-bit midpoint, so a full bit period
        // later lands in the middle of each data bit.
        if (cnt_q == c_full_m1) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == c_full_m1) begin
          cnt_d   = '0;
          // Even parity: data bits plus parity bit must have an even count of ones.
          pbad_d  = rx_s_q ^ (^shift_q);
          perr_d  = rx_s_q ^ (^shift_q);
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == c_full_m1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (!rx_s_q) begin
            ferr_d = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          else if (!pbad_q) begin
            byte_done = 1'b1;
          end
`else
          else begin
            byte_done = 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Holding register: full and not being drained means the new byte is lost.
    if (byte_done) begin
      if (valid_q && !rx_ready) begin
        ovr_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end
  end

  assign rx_valid     = valid_q;
  assign rx_data      = data_q;
  assign rx_frame_err = ferr_q;
  assign rx_overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = perr_q;
`endif

endmodule
`default_nettype wire

// File: doc/rx_core.md
RX_CORE -- requirements
Module: rx_core

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning rx_clk cycles per serial bit (even, >=4).
REQ-002 SHALL have port rx_clk  input  1  the only clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-006 SHALL have port rx_data  output  8  received byte, LSB first on the line.
REQ-007 SHALL have port rx_ready  input  1  sink accepts the byte when rx_valid and rx_ready are both high.
REQ-008 SHALL have port rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port rx_overrun  output  1  one-cycle pulse: a completed byte was dropped because the holding register was full.

Function
REQ-010 SHALL pass rx through a two-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-011 SHALL implement states IDLE, START, DATA, STOP (plus PARITY under REQ-024).
REQ-012 IDLE: a falling edge (rx_s low, previous rx_s high) SHALL enter START with the bit counter cleared to 0.
REQ-013 START: at counter = CLKS_PER_BIT/2-1 SHALL sample rx_s; low -> DATA with counter 0 and bit index 0; high -> IDLE (false start, no output activity).
REQ-014 DATA: each bit SHALL be sampled at counter = CLKS_PER_BIT-1, so samples land mid-bit, shifted in LSB first; after bit 7 -> STOP.
REQ-015 STOP: at counter = CLKS_PER_BIT-1 SHALL sample rx_s; high -> byte complete; low -> rx_frame_err pulse, byte discarded; either way -> IDLE the next cycle.
REQ-016 A line held low after a frame error SHALL NOT start a new frame until a fresh falling edge is seen.
REQ-017 On byte complete, SHALL load rx_data and raise rx_valid on the following cycle.
REQ-018 Latency at CLKS_PER_BIT=16: rx_valid SHALL rise 155 +/-1 cycles after the rx pin falls.
REQ-019 rx_valid and rx_data SHALL stay stable until a cycle with rx_valid && rx_ready; rx_valid SHALL drop the next cycle unless a new byte loads in the same cycle.
REQ-020 Byte completes while rx_valid is high and rx_ready is low: SHALL keep the old byte, drop the new one, and pulse rx_overrun.
REQ-021 Byte completes in the same cycle as an accept: SHALL load the new byte, keep rx_valid high, and not pulse rx_overrun.
REQ-022 rx_ready SHALL have no effect while rx_valid is low; reception SHALL never stall on rx_ready.

Reset
REQ-023 On reset high at a rising edge: state IDLE, counters 0, synchronizer flops 1, rx_valid 0, rx_data 8'h00, rx_frame_err 0, rx_overrun 0; a frame in progress is abandoned with no pulse; after reset the block waits for a fresh falling edge.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: a PARITY state between DATA and STOP SHALL sample one even-parity bit at counter = CLKS_PER_BIT-1; a mismatch SHALL pulse extra output rx_parity_err (1-bit, reset 0), discard the byte, and still check the stop bit; latency grows by CLKS_PER_BIT.
REQ-025 Macro undefined: no PARITY state, no rx_parity_err port; frame is 8N1.

Verification
REQ-026 CLKS_PER_BIT=16, rx_ready=1, send 8N1 byte 0xA5 -> rx_valid for exactly 1 cycle, rx_data=0xA5, 155 +/-1 cycles after the start edge, no error pulses.
REQ-027 rx_ready=0, send 0x3C then 0xC3 -> rx_data stays 0x3C, one rx_overrun pulse at 0xC3 completion; raise rx_ready -> rx_valid drops the next cycle.
REQ-028 Send 0x55 with stop bit low -> one rx_frame_err pulse, rx_valid stays 0; next frame 0x12 with a proper idle gap is received correctly.
REQ-029 Low glitch of 4 cycles on rx -> returns to IDLE, no rx_valid, no error pulses.
REQ-030 Assert reset at DATA bit 3 of 0xFF -> all outputs at reset values, no rx_valid; subsequent 0x81 is received correctly.
REQ-031 UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 -> rx_parity_err pulse, no rx_valid; with parity bit 1 -> rx_data=0x07.
